dac_spi_arbiter: RTL and testbench

DAC_SPI_ARBITER -- requirements
Module: dac_spi_arbiter

---
 rtl/dac_pkg.sv | 13 +
 rtl/dac_holdoff_timer.sv | 30 +++
 rtl/dac_spi_arbiter.sv | 113 +++++++++++
 tb/tb_dac_spi_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared DAC arbiter types: code width, requester count and arbiter state encoding.
package dac_pkg;

  localparam int DAC_DATA_W  = 12;
  localparam int NUM_DAC_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_HOLDOFF   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dac_holdoff_timer.sv
// Chip-select high-time timer: load on frame done, count down while enabled, flag the last cycle.
// o_expired is high in the final holdoff cycle so the owner FSM leaves on that edge.
module dac_holdoff_timer #(
  parameter int CYCLES = 25
) (
  input  logic i_Clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(CYCLES);
    end else if (i_en && (r_count != '0)) begin
      // Saturates at zero rather than wrapping.
      r_count <= r_count - CW'(1);
    end
  end

  assign o_expired = (r_count <= CW'(1));

endmodule

// File: rtl/dac_spi_arbiter.sv
// Two-requester arbiter for a shared DAC SPI master, with enforced CS_n high time between frames.
// Define DAC_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise requester 0 wins ties.
module dac_spi_arbiter
  import dac_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 25,
  parameter int DATA_W         = DAC_DATA_W
) (
  input  logic              i_Clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_done0,
  output logic              o_done1,
  output logic              o_dac_start,
  output logic [DATA_W-1:0] o_dac_data,
  input  logic              i_dac_done,
  output logic              o_busy,
  output logic              o_owner
);

  arb_state_t r_state;
  logic       w_pick1;
  logic       w_hold_load;
  logic       w_hold_en;
  logic       w_hold_expired;

`ifdef DAC_ARB_ROUND_ROBIN_EN
  logic r_last;
  assign w_pick1 = i_req1 & (~i_req0 | ~r_last);
`else
  assign w_pick1 = i_req1 & ~i_req0;
`endif

  assign w_hold_load = (r_state == ST_WAIT_DONE) & i_dac_done;
  assign w_hold_en   = (r_state == ST_HOLDOFF);

  dac_holdoff_timer #(
    .CYCLES (HOLDOFF_CYCLES)
  ) u_holdoff (
    .i_Clk     (i_Clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_hold_load),
    .i_en      (w_hold_en),
    .o_expired (w_hold_expired)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      o_gnt0      <= 1'b0;
      o_gnt1      <= 1'b0;
      o_done0     <= 1'b0;
      o_done1     <= 1'b0;
      o_dac_start <= 1'b0;
      o_dac_data  <= '0;
      o_busy      <= 1'b0;
      o_owner     <= 1'b0;
`ifdef DAC_ARB_ROUND_ROBIN_EN
      r_last      <= 1'b1;
`endif
    end else begin
      o_gnt0      <= 1'b0;
      o_gnt1      <= 1'b0;
      o_done0     <= 1'b0;
      o_done1     <= 1'b0;
      o_dac_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req0 || i_req1) begin
            o_gnt0      <= ~w_pick1;
            o_gnt1      <= w_pick1;
            o_dac_start <= 1'b1;
            o_dac_data  <= w_pick1 ? i_data1 : i_data0;
            o_owner     <= w_pick1;
            o_busy      <= 1'b1;
            r_state     <= ST_WAIT_DONE;
`ifdef DAC_ARB_ROUND_ROBIN_EN
            r_last      <= w_pick1;
`endif
          end
        end
        ST_WAIT_DONE: begin
          if (i_dac_done) begin
            o_done0 <= ~o_owner;
            o_done1 <= o_owner;
            if (HOLDOFF_CYCLES == 0) begin
              r_state <= ST_IDLE;
              o_busy  <= 1'b0;
            end else begin
              r_state <= ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          if (w_hold_expired) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Bench for dac_spi_arbiter: reset/grant table, directed corner sequences, and random traffic vs a timing model.
module tb_dac_spi_arbiter;

  localparam int HOLD = 25;
  localparam int DW   = 12;
`ifdef DAC_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          i_Clk = 1'b0;
  logic          i_rst_n, i_req0, i_req1, i_dac_done;
  logic [DW-1:0] i_data0, i_data1;
  logic          o_gnt0, o_gnt1, o_done0, o_done1, o_dac_start, o_busy, o_owner;
  logic [DW-1:0] o_dac_data;

  dac_spi_arbiter #(.HOLDOFF_CYCLES(HOLD), .DATA_W(DW)) dut (
    .i_Clk(i_Clk), .i_rst_n(i_rst_n), .i_req0(i_req0), .i_req1(i_req1),
    .i_data0(i_data0), .i_data1(i_data1), .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
    .o_done0(o_done0), .o_done1(o_done1), .o_dac_start(o_dac_start),
    .o_dac_data(o_dac_data), .i_dac_done(i_dac_done), .o_busy(o_busy), .o_owner(o_owner)
  );

  always #20 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a frame is open from grant until done; the DAC is free again HOLD+1 edges after done.
  logic          m_open, m_last, m_owner, m_busy;
  logic          m_gnt0, m_gnt1, m_start, m_done0, m_done1;
  logic [DW-1:0] m_data;
  int            m_free_at;

  function automatic logic [31:0] dut_vec();
    return {13'd0, o_gnt0, o_gnt1, o_dac_start, o_done0, o_done1, o_busy, o_owner, o_dac_data};
  endfunction

  function automatic logic [31:0] mk_vec(logic g0, logic g1, logic st, logic d0, logic d1,
                                         logic bz, logic ow, logic [DW-1:0] dat);
    return {13'd0, g0, g1, st, d0, d1, bz, ow, dat};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic pick1;
    m_gnt0 = 0; m_gnt1 = 0; m_start = 0; m_done0 = 0; m_done1 = 0;
    if (!i_rst_n) begin
      m_open = 0; m_free_at = 0; m_last = 1; m_owner = 0; m_data = '0; m_busy = 0;
    end else if (!m_open && cyc >= m_free_at && (i_req0 || i_req1)) begin
      pick1   = (i_req0 && i_req1) ? (RR ? !m_last : 1'b0) : i_req1;
      m_gnt0  = !pick1;
      m_gnt1  = pick1;
      m_start = 1;
      m_data  = pick1 ? i_data1 : i_data0;
      m_owner = pick1;
      m_last  = pick1;
      m_open  = 1;
      m_busy  = 1;
    end else if (m_open && i_dac_done) begin
      m_done0   = !m_owner;
      m_done1   = m_owner;
      m_open    = 0;
      m_free_at = cyc + HOLD + 1;
      m_busy    = (HOLD > 0);
    end else if (!m_open) begin
      m_busy = (cyc < m_free_at - 1);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    cyc++;
    model_edge();
    @(negedge i_Clk);
    check($sformatf("model_c%0d", cyc), dut_vec(),
          mk_vec(m_gnt0, m_gnt1, m_start, m_done0, m_done1, m_busy, m_owner, m_data));
  endtask

  typedef struct {
    logic          rst_n, req0, req1, done;
    logic [DW-1:0] d0, d1;
    logic          g0, g1, st, dn0, dn1, bz, ow;
    logic [DW-1:0] dat;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int done_edge, start_edge, n_g1, dly;
    logic got;
    logic exp_own;

    i_rst_n = 0; i_req0 = 0; i_req1 = 0; i_dac_done = 0; i_data0 = '0; i_data1 = '0;
    m_open = 0; m_last = 1; m_owner = 0; m_busy = 0; m_data = '0; m_free_at = 0;
    m_gnt0 = 0; m_gnt1 = 0; m_start = 0; m_done0 = 0; m_done1 = 0;

    //             rst req0 req1 done  d0       d1       g0 g1 st dn0 dn1 bz ow  dat
    tbl[0]  = '{0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h000};
    tbl[1]  = '{1, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h000};
    tbl[2]  = '{1, 1, 0, 0, 12'h800, 12'h000, 1, 0, 1, 0, 0, 1, 0, 12'h800};
    tbl[3]  = '{1, 0, 0, 0, 12'h800, 12'h000, 0, 0, 0, 0, 0, 1, 0, 12'h800};
    tbl[4]  = '{1, 0, 0, 1, 12'h800, 12'h000, 0, 0, 0, 1, 0, 1, 0, 12'h800};
    tbl[5]  = '{1, 0, 0, 0, 12'h800, 12'h000, 0, 0, 0, 0, 0, 1, 0, 12'h800};
    tbl[6]  = '{1, 0, 0, 1, 12'h800, 12'h000, 0, 0, 0, 0, 0, 1, 0, 12'h800};
    tbl[7]  = '{1, 0, 1, 0, 12'h800, 12'h222, 0, 0, 0, 0, 0, 1, 0, 12'h800};
    tbl[8]  = '{0, 0, 1, 0, 12'h800, 12'h222, 0, 0, 0, 0, 0, 0, 0, 12'h000};
    tbl[9]  = '{1, 0, 1, 0, 12'h800, 12'h222, 0, 1, 1, 0, 0, 1, 1, 12'h222};
    tbl[10] = '{1, 0, 0, 0, 12'h800, 12'h222, 0, 0, 0, 0, 0, 1, 1, 12'h222};
    tbl[11] = '{0, 0, 0, 0, 12'h800, 12'h222, 0, 0, 0, 0, 0, 0, 0, 12'h000};
    tbl[12] = '{1, 0, 0, 1, 12'h800, 12'h222, 0, 0, 0, 0, 0, 0, 0, 12'h000};
    tbl[13] = '{1, 1, 1, 0, 12'h111, 12'h222, 1, 0, 1, 0, 0, 1, 0, 12'h111};
    tbl[14] = '{1, 1, 1, 0, 12'h111, 12'h222, 0, 0, 0, 0, 0, 1, 0, 12'h111};
    tbl[15] = '{0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h000};

    @(negedge i_Clk);
    for (int i = 0; i < 16; i++) begin
      i_rst_n = tbl[i].rst_n; i_req0 = tbl[i].req0; i_req1 = tbl[i].req1;
      i_dac_done = tbl[i].done; i_data0 = tbl[i].d0; i_data1 = tbl[i].d1;
      step();
      check($sformatf("table%0d", i), dut_vec(),
            mk_vec(tbl[i].g0, tbl[i].g1, tbl[i].st, tbl[i].dn0, tbl[i].dn1,
                   tbl[i].bz, tbl[i].ow, tbl[i].dat));
    end

    // Single request, holdoff spacing and busy release.
    i_rst_n = 1; step();
    i_req0 = 1; i_data0 = 12'h800; step();
    check("single_grant", {o_gnt0, o_dac_start, o_dac_data}, {1'b1, 1'b1, 12'h800});
    i_req0 = 0; step(); step(); step();
    i_dac_done = 1; step();
    check("single_done0", o_done0, 1'b1);
    i_dac_done = 0; done_edge = cyc;
    i_req1 = 1; i_data1 = 12'h333;
    got = 0; start_edge = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      step();
      if (cyc == done_edge + HOLD - 1) check("busy_last_holdoff", o_busy, 1'b1);
      if (cyc == done_edge + HOLD)     check("busy_released", o_busy, 1'b0);
      if (o_dac_start) begin got = 1; start_edge = cyc; end
    end
    check("holdoff_start_seen", got, 1'b1);
    check("holdoff_gap", start_edge - done_edge, HOLD + 1);
    check("holdoff_owner", {o_gnt1, o_owner, o_dac_data}, {1'b1, 1'b1, 12'h333});
    i_req1 = 0; step();
    i_dac_done = 1; step();
    check("done1_pulse", {o_done0, o_done1}, 2'b01);
    i_dac_done = 0;

    // Persistent tie: round-robin alternates, fixed priority stays on 0.
    i_rst_n = 0; step(); i_rst_n = 1; step();
    i_req0 = 1; i_req1 = 1; i_data0 = 12'h111; i_data1 = 12'h222;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int k = 0; k < 100 && !got; k++) begin
        step();
        if (o_dac_start) got = 1;
      end
      check($sformatf("tie%0d_seen", g), got, 1'b1);
      exp_own = RR ? g[0] : 1'b0;
      check($sformatf("tie%0d_owner", g), {o_owner, o_gnt1, o_gnt0}, {exp_own, exp_own, !exp_own});
      check($sformatf("tie%0d_data", g), o_dac_data, exp_own ? 12'h222 : 12'h111);
      i_dac_done = 1; step(); i_dac_done = 0;
    end
    i_req0 = 0; i_req1 = 0;

    // Reset mid-frame, then a late done.
    i_rst_n = 0; step(); i_rst_n = 1; step();
    i_req0 = 1; i_data0 = 12'h5a5; step();
    i_req0 = 0; step();
    check("midframe_busy", o_busy, 1'b1);
    i_rst_n = 0; step();
    check("midframe_reset_zero", dut_vec(), 32'd0);
    i_rst_n = 1; i_dac_done = 1; step();
    check("late_done_ignored", dut_vec(), 32'd0);
    i_dac_done = 0; step();
    check("idle_after_reset", o_busy, 1'b0);

    // Withdrawn request during a frame, then a stray done in IDLE.
    i_req0 = 1; i_data0 = 12'h123; step();
    i_req0 = 0; step();
    i_req1 = 1; i_data1 = 12'h456; n_g1 = 0; step(); n_g1 += o_gnt1;
    i_req1 = 0; step(); n_g1 += o_gnt1;
    i_dac_done = 1; step(); n_g1 += o_gnt1;
    i_dac_done = 0;
    for (int k = 0; k < HOLD + 10; k++) begin step(); n_g1 += o_gnt1; end
    check("withdrawn_no_grant", n_g1, 0);
    i_dac_done = 1; step();
    check("stray_done_idle", dut_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0, 12'h123));
    i_dac_done = 0;

    // Random traffic against the model, with a stub SPI master answering each start.
    i_rst_n = 0; step(); i_rst_n = 1;
    dly = 0;
    for (int n = 0; n < 3000; n++) begin
      i_rst_n = ($urandom_range(0, 499) != 0);
      i_dac_done = 0;
      if (dly > 0) begin dly--; if (dly == 0) i_dac_done = 1; end
      if ($urandom_range(0, 19) == 0) i_dac_done = 1;
      if (i_req0) begin
        if ((o_gnt0 && $urandom_range(0, 3) != 0) || $urandom_range(0, 15) == 0) i_req0 = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        i_req0 = 1; i_data0 = DW'($urandom);
      end
      if (i_req1) begin
        if ((o_gnt1 && $urandom_range(0, 3) != 0) || $urandom_range(0, 15) == 0) i_req1 = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        i_req1 = 1; i_data1 = DW'($urandom);
      end
      step();
      if (o_dac_start) dly = $urandom_range(1, 8);
      if (!i_rst_n) dly = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
